prog_counter_ras: RTL and testbench
===================================

PROG_COUNTER_RAS -- requirements
Module: prog_counter_ras

Interface
REQ-001 Parameter INSTR_WIDTH, default 9: width of program counter and start_addr.
REQ-002 Parameter REG_WIDTH, default 8: width of signed branch offset/target.
REQ-003 Parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, >=2.
REQ-004 Parameter SKIP, default 2: increment applied on a not-taken branch.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 start  input  1  synchronous active-high reset; loads start_addr and clears stack/flags.
REQ-007 start_addr  input  INSTR_WIDTH  PC value loaded while start=1.
REQ-008 stall  input  1  freeze all state for this cycle.
REQ-009 branch  input  1  current instruction is a conditional branch.
REQ-010 taken  input  1  branch/jump is taken.
REQ-011 abs_jump  input  1  taken transfer uses target as absolute address, not offset.
REQ-012 call  input  1  taken relative jump plus push of return address.
REQ-013 ret  input  1  pop stack top into PC.
REQ-014 target  input  REG_WIDTH signed  offset or absolute address.
REQ-015 pc_out  output  INSTR_WIDTH  current PC, registered.
REQ-016 ras_count  output  $clog2(RAS_DEPTH)+1  valid stack entries.
REQ-017 ras_full / ras_empty  output  1 each  ras_count==RAS_DEPTH / ras_count==0.
REQ-018 ras_err  output  1  sticky overflow/underflow/conflict flag.

Function
REQ-019 Next-PC priority, highest first: start, stall, ret, call, taken, branch, default.
REQ-020 start: pc<=start_addr; overrides stall and all other inputs.
REQ-021 stall (start=0): pc, stack, ras_count, ras_err all hold.
REQ-022 Default: pc<=pc+1; branch&!taken: pc<=pc+SKIP.
REQ-023 taken&!abs_jump: pc<=pc+sign_extend(target); REG_WIDTH>INSTR_WIDTH truncates target to INSTR_WIDTH.
REQ-024 taken&abs_jump: pc<=target zero-extended/truncated to INSTR_WIDTH.
REQ-025 All PC arithmetic modulo 2^INSTR_WIDTH; wrap silently, no flag.
REQ-026 call: pc<=pc+sign_extend(target) (abs_jump and taken ignored); push pc+1; ras_count+1.
REQ-027 call while ras_full: push overwrites oldest entry (circular), ras_count stays RAS_DEPTH, ras_err<=1.
REQ-028 ret with ras_count>0: pc<=top entry; ras_count-1; latency one cycle (target visible on pc_out next cycle).
REQ-029 ret while ras_empty: pc<=pc+1, ras_count stays 0, ras_err<=1.
REQ-030 call&ret same cycle: ret performed, call ignored, ras_err<=1.
REQ-031 ras_err clears only on start.

Reset
REQ-032 On start: pc_out=start_addr, ras_count=0, ras_empty=1, ras_full=0, ras_err=0 on next edge; stack contents need not be cleared.
REQ-033 start asserted mid-sequence (e.g. during a call/ret) discards that operation entirely.

Configuration
REQ-034 Macro PC_RAS_EN defined: stack, call/ret behaviour per REQ-026..REQ-030.
REQ-035 PC_RAS_EN undefined: no stack storage; call acts as taken relative jump; ret acts as default increment; ras_count=0, ras_empty=1, ras_full=0, ras_err=0 constantly.

Verification
REQ-036 start=1, start_addr=0x010 -> pc_out=0x010; then 3 idle cycles -> 0x011, 0x012, 0x013.
REQ-037 pc=0x020, taken, target=-4 -> 0x01C; pc=0x1FF default -> 0x000; branch&!taken at 0x030 -> 0x032.
REQ-038 call target=+16 at 0x040 -> pc 0x050, ras_count 1; ret -> 0x041, ras_count 0, ras_err 0.
REQ-039 RAS_DEPTH=4: 5 nested calls -> ras_count 4, ras_full 1, ras_err 1; 4 rets return to last four return addresses, 5th ret -> pc+1.
REQ-040 stall=1 with taken/call/ret asserted for 3 cycles -> pc_out and ras_count unchanged; start during stall -> pc_out=start_addr, ras_err 0.
REQ-041 PC_RAS_EN undefined: call target=+8 at 0x000 -> 0x008; ret -> 0x009; flags constant.

Source files
------------

// File: rtl/prog_counter_ras_if.sv
// Bundle of the program-counter control inputs and PC/return-stack status outputs.
// The testbench drives the master side and the prog_counter_ras core takes the slave side.
interface prog_counter_ras_if #(
  parameter int INSTR_WIDTH = 9,
  parameter int REG_WIDTH   = 8,
  parameter int RAS_DEPTH   = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic [INSTR_WIDTH-1:0]      start_addr;
  logic                        stall;
  logic                        branch;
  logic                        taken;
  logic                        abs_jump;
  logic                        call;
  logic                        ret;
  logic signed [REG_WIDTH-1:0] target;

  logic [INSTR_WIDTH-1:0]      pc_out;
  logic [CNT_W-1:0]            ras_count;
  logic                        ras_full;
  logic                        ras_empty;
  logic                        ras_err;

  modport master (
    output start_addr, stall, branch, taken, abs_jump, call, ret, target,
    input  pc_out, ras_count, ras_full, ras_empty, ras_err
  );

  modport slave (
    input  start_addr, stall, branch, taken, abs_jump, call, ret, target,
    output pc_out, ras_count, ras_full, ras_empty, ras_err
  );
endinterface

// File: rtl/prog_counter_ras.sv
// Program counter with branch/jump/call/return and a circular return-address stack.
// The stack is built only when PC_RAS_EN is defined; otherwise call is a relative jump and ret increments.
module prog_counter_ras #(
  parameter int INSTR_WIDTH = 9,
  parameter int REG_WIDTH   = 8,
  parameter int RAS_DEPTH   = 4,
  parameter int SKIP        = 2
) (
  input logic               clk,
  input logic               start,
  prog_counter_ras_if.slave bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [INSTR_WIDTH-1:0] pc_t;

  pc_t pc_q, pc_d;
  pc_t pc_inc, pc_skip, pc_rel, pc_abs;

  // Size casts: sign-extend or truncate the offset, zero-extend or truncate the absolute target.
  always_comb begin
    pc_inc  = pc_q + pc_t'(1);
    pc_skip = pc_q + pc_t'(SKIP);
    pc_rel  = pc_q + INSTR_WIDTH'(bus.target);
    pc_abs  = INSTR_WIDTH'($unsigned(bus.target));
  end

  assign bus.pc_out = pc_q;

`ifdef PC_RAS_EN
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, top_ptr;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             push;
  logic             full, empty;
  pc_t              stack_q [RAS_DEPTH];

  // wr_ptr is the next free slot; a push when full lands on the oldest entry.
  assign top_ptr = wr_ptr_q - PTR_W'(1);
  assign full    = (count_q == CNT_W'(RAS_DEPTH));
  assign empty   = (count_q == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    pc_d     = pc_inc;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    push     = 1'b0;
    if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.ret) begin
      if (bus.call || empty) err_d = 1'b1;
      if (!empty) begin
        pc_d     = stack_q[top_ptr];
        wr_ptr_d = top_ptr;
        count_d  = count_q - CNT_W'(1);
      end
    end else if (bus.call) begin
      pc_d     = pc_rel;
      push     = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (full) err_d   = 1'b1;
      else      count_d = count_q + CNT_W'(1);
    end else if (bus.taken) begin
      pc_d = bus.abs_jump ? pc_abs : pc_rel;
    end else if (bus.branch) begin
      pc_d = pc_skip;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so all updates see pre-edge values.
    if (start) begin
      pc_q     <= bus.start_addr;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the stack array has no reset; ras_count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !start) stack_q[wr_ptr_q] <= pc_inc;
  end

  assign bus.ras_count = count_q;
  assign bus.ras_full  = full;
  assign bus.ras_empty = empty;
  assign bus.ras_err   = err_q;
`else
  always_comb begin
    pc_d = pc_inc;
    if (bus.stall)       pc_d = pc_q;
    else if (bus.ret)    pc_d = pc_inc;
    else if (bus.call)   pc_d = pc_rel;
    else if (bus.taken)  pc_d = bus.abs_jump ? pc_abs : pc_rel;
    else if (bus.branch) pc_d = pc_skip;
  end

  always_ff @(posedge clk) begin
    if (start) pc_q <= bus.start_addr;
    else       pc_q <= pc_d;
  end

  assign bus.ras_count = CNT_W'(0);
  assign bus.ras_full  = 1'b0;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_err   = 1'b0;
`endif
endmodule

// File: tb/tb_prog_counter_ras.sv
// Self-checking bench for prog_counter_ras: directed vector table, nested call/return
// sequence, then random traffic against a queue-based reference model.
module tb_prog_counter_ras;
  localparam int IW    = 9;
  localparam int RW    = 8;
  localparam int DEPTH = 4;
  localparam int SKIP  = 2;
  localparam int MOD   = 1 << IW;
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic start;

  prog_counter_ras_if #(.INSTR_WIDTH(IW), .REG_WIDTH(RW), .RAS_DEPTH(DEPTH)) bus ();

  prog_counter_ras #(
    .INSTR_WIDTH(IW), .REG_WIDTH(RW), .RAS_DEPTH(DEPTH), .SKIP(SKIP)
  ) dut (
    .clk  (clk),
    .start(start),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic [IW-1:0] start_addr;
    logic          stall, branch, taken, abs_jump, call, ret;
    logic [RW-1:0] target;
    logic [IW-1:0] exp_pc;
    int            exp_cnt;
    logic          exp_err;
  } vec_t;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit st, int sa, bit stl, bit br, bit tk, bit ab, bit ca, bit re,
                              int tg, int pc, int cnt, bit err);
    vec_t v;
    v.start = st; v.start_addr = IW'(sa); v.stall = stl; v.branch = br; v.taken = tk;
    v.abs_jump = ab; v.call = ca; v.ret = re; v.target = RW'(tg);
    v.exp_pc = IW'(pc); v.exp_cnt = cnt; v.exp_err = err;
    return v;
  endfunction

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    start          = v.start;
    bus.start_addr = v.start_addr;
    bus.stall      = v.stall;
    bus.branch     = v.branch;
    bus.taken      = v.taken;
    bus.abs_jump   = v.abs_jump;
    bus.call       = v.call;
    bus.ret        = v.ret;
    bus.target     = v.target;
    @(posedge clk);
    #1;
    check({tag, ".pc"},    32'(bus.pc_out),    32'(v.exp_pc));
    check({tag, ".count"}, 32'(bus.ras_count), 32'(v.exp_cnt));
    check({tag, ".full"},  32'(bus.ras_full),  32'(v.exp_cnt == DEPTH));
    check({tag, ".empty"}, 32'(bus.ras_empty), 32'(v.exp_cnt == 0));
    check({tag, ".err"},   32'(bus.ras_err),   32'(v.exp_err));
  endtask

  // Reference model: PC as an integer modulo 2^IW, the stack as a queue (back = top).
  int m_pc;
  int m_stack[$];
  bit m_err;

  function automatic int wrap(int x);
    return ((x % MOD) + MOD) % MOD;
  endfunction

  function automatic void model_step(vec_t v);
    int off;
    off = int'($signed(v.target));
    if (v.start) begin
      m_pc = int'(v.start_addr);
      m_stack.delete();
      m_err = 1'b0;
    end else if (v.stall) begin
      m_pc = m_pc;
    end else if (v.ret) begin
      if (!RAS_EN) m_pc = wrap(m_pc + 1);
      else begin
        if (v.call) m_err = 1'b1;
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin
          m_pc  = wrap(m_pc + 1);
          m_err = 1'b1;
        end
      end
    end else if (v.call) begin
      if (RAS_EN) begin
        m_stack.push_back(wrap(m_pc + 1));
        if (m_stack.size() > DEPTH) begin
          void'(m_stack.pop_front());
          m_err = 1'b1;
        end
      end
      m_pc = wrap(m_pc + off);
    end else if (v.taken) begin
      m_pc = v.abs_jump ? int'(v.target) : wrap(m_pc + off);
    end else if (v.branch) begin
      m_pc = wrap(m_pc + SKIP);
    end else begin
      m_pc = wrap(m_pc + 1);
    end
  endfunction

  vec_t tbl[$];
  bit   r;

  initial begin
    r = RAS_EN;
    start = 1'b0; bus.start_addr = '0; bus.stall = 1'b0; bus.branch = 1'b0; bus.taken = 1'b0;
    bus.abs_jump = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.target = '0;

    //           st  sa    stl br tk ab ca re tg     pc                      cnt      err
    tbl.push_back(mk(1, 'h010, 0, 0, 0, 0, 0, 0, 0,    'h010,                  0,       0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 0, 0, 0,    'h011,                  0,       0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 0, 0, 0,    'h012,                  0,       0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 0, 0, 0,    'h013,                  0,       0));
    tbl.push_back(mk(1, 'h020, 0, 0, 0, 0, 0, 0, 0,    'h020,                  0,       0));
    tbl.push_back(mk(0, 0,     0, 0, 1, 0, 0, 0, 'hFC, 'h01C,                  0,       0));
    tbl.push_back(mk(1, 'h1FF, 0, 0, 0, 0, 0, 0, 0,    'h1FF,                  0,       0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 0, 0, 0,    'h000,                  0,       0));
    tbl.push_back(mk(1, 'h030, 0, 0, 0, 0, 0, 0, 0,    'h030,                  0,       0));
    tbl.push_back(mk(0, 0,     0, 1, 0, 0, 0, 0, 0,    'h032,                  0,       0));
    tbl.push_back(mk(0, 0,     0, 0, 1, 1, 0, 0, 'h85, 'h085,                  0,       0));
    tbl.push_back(mk(0, 0,     0, 0, 1, 0, 0, 0, 'h85, 'h00A,                  0,       0));
    tbl.push_back(mk(0, 0,     0, 1, 1, 0, 0, 0, 'h7F, 'h089,                  0,       0));
    tbl.push_back(mk(1, 'h040, 0, 0, 0, 0, 0, 0, 0,    'h040,                  0,       0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 1, 0, 'h10, 'h050,                  r ? 1:0, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 0, 1, 'h10, r ? 'h041 : 'h051,      0,       0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 1, 0, 'h10, r ? 'h051 : 'h061,      r ? 1:0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0,   1, 0, 1, 0, 1, 1, 'h33, r ? 'h051 : 'h061,      r ? 1:0, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 0, 1, 0,    r ? 'h042 : 'h062,      0,       0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 0, 1, 0,    r ? 'h043 : 'h063,      0,       r));
    tbl.push_back(mk(1, 'h100, 1, 0, 1, 0, 1, 1, 0,    'h100,                  0,       0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 1, 0, 'h02, 'h102,                  r ? 1:0, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 1, 1, 'h32, r ? 'h101 : 'h103,      0,       r));
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 1, 1, 'h32, 'h000,                  0,       0));
    tbl.push_back(mk(0, 0,     0, 0, 1, 1, 1, 0, 'h08, 'h008,                  r ? 1:0, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 0, 1, 0,    r ? 'h001 : 'h009,      0,       0));

    foreach (tbl[i]) apply($sformatf("tbl[%0d]", i), tbl[i]);

    // Five nested calls into a four-deep stack, then five returns.
    apply("nest.start", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      apply($sformatf("nest.call%0d", i),
            mk(0, 0, 0, 0, 0, 0, 1, 0, 'h10, 16 * (i + 1),
               r ? ((i + 1 > DEPTH) ? DEPTH : i + 1) : 0, r && (i == 4)));
    for (int i = 0; i < 4; i++)
      apply($sformatf("nest.ret%0d", i),
            mk(0, 0, 0, 0, 0, 0, 0, 1, 0, r ? 16 * (4 - i) + 1 : 81 + i, r ? 3 - i : 0, r));
    apply("nest.ret4", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, r ? 18 : 85, 0, r));

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      vec_t v;
      v.start      = (i == 0) || ($urandom_range(0, 39) == 0);
      v.start_addr = IW'($urandom);
      v.stall      = ($urandom_range(0, 7) == 0);
      v.branch     = $urandom_range(0, 1) == 1;
      v.taken      = $urandom_range(0, 2) == 0;
      v.abs_jump   = $urandom_range(0, 1) == 1;
      v.call       = $urandom_range(0, 3) == 0;
      v.ret        = $urandom_range(0, 3) == 0;
      v.target     = RW'($urandom);
      model_step(v);
      v.exp_pc  = IW'(m_pc);
      v.exp_cnt = m_stack.size();
      v.exp_err = m_err;
      apply($sformatf("rnd[%0d]", i), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
